// File: rtl/miner_pkg.sv
// Shared definitions for the miner job loader.
// Holds the loader FSM state enum, the message block type and the sizing
// constants that the loader and its block-mask sub-module both rely on.
package miner_pkg;

    localparam int NONCE_BYTE_LEN = 24;                  // nonce bytes at the head of block 0
    localparam int NONCE_BITS     = NONCE_BYTE_LEN * 8;
    localparam int NONCE_WORDS    = NONCE_BYTE_LEN / 4;  // words 0..5 of the message
    localparam int MAX_HDR_BYTES  = 1000;
    localparam int MAX_MSG_BYTES  = 1024;
    localparam int MSG_WORDS      = 16;                  // 32-bit words per 512-bit block
    localparam int MEM_DEPTH      = 256;                 // MAX_MSG_BYTES / 4
    localparam int HDR_WORDS      = MAX_HDR_BYTES / 4;   // header words that fit behind the nonce slot
    localparam int BYTE_NUM_W     = 11;                  // holds 0..MAX_MSG_BYTES
    localparam int PTR_W          = 4;                   // block pointer, blocks 0..15
    localparam int WCNT_W         = 8;                   // write counter / storage index width

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ARM,
        ST_RUN
    } loader_state_t;

    // Word w of the block lives at [w]; byte lane 0 of a word is bits [31:24].
    typedef logic [MSG_WORDS-1:0][31:0] msg_block_t;

endpackage

// File: rtl/msg_block_mask.sv
// Zeroes every byte of a 512-bit block whose message byte index is at or
// beyond the message length.
// Ports:
//   ptr          - block pointer (block number within the message)
//   byte_num     - total message length in bytes
//   raw_words    - unmasked block read from storage
//   masked_words - block with out-of-message bytes forced to zero
module msg_block_mask
    import miner_pkg::*;
(
    input  logic [PTR_W-1:0]      ptr,
    input  logic [BYTE_NUM_W-1:0] byte_num,
    input  msg_block_t            raw_words,
    output msg_block_t            masked_words
);

    genvar gi, gl;
    generate
        for (gi = 0; gi < MSG_WORDS; gi++) begin : g_word
            for (gl = 0; gl < 4; gl++) begin : g_lane
                logic [BYTE_NUM_W-1:0] byte_idx;
                // ptr*64 + word*4 + lane, built by concatenation
                assign byte_idx = {1'b0, ptr, 6'(gi * 4 + gl)};
                assign masked_words[gi][31-8*gl -: 8] =
                    (byte_idx < byte_num) ? raw_words[gi][31-8*gl -: 8] : 8'h00;
            end
        end
    endgenerate

endmodule

// File: rtl/miner_job_loader.sv
// Job loader for the miner core. Collects a header as a 32-bit word stream
// behind a zeroed nonce slot, arms the miner with a one-cycle Update_O pulse,
// then serves masked 512-bit blocks selected by a pointer that advances on
// Next_I and rewinds on Rdy_I. Found_I or Abort_I clears the miner.
// Ports:
//   Clk, Rst_n                     - clock, asynchronous active-low reset
//   WrVld_I/WrData_I/WrLast_I      - header word stream, WrRdy_O backpressure
//   HdrBytes_I, Nonce_I            - job length and start nonce, taken with WrLast_I
//   Abort_I, Next_I, Rdy_I, Found_I - job control / miner handshakes
//   Update_O, Clear_O              - one-cycle miner start / clear pulses
//   Msg_O                          - current masked block
//   ByteNum_O, Nonce_O             - latched message length and start nonce
//   Busy_O, Err_O                  - job armed/running, sticky overflow flag
module miner_job_loader
    import miner_pkg::*;
(
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  WrVld_I,
    input  logic [31:0]           WrData_I,
    input  logic                  WrLast_I,
    input  logic [BYTE_NUM_W-1:0] HdrBytes_I,
    input  logic [NONCE_BITS-1:0] Nonce_I,
    output logic                  WrRdy_O,
    input  logic                  Abort_I,
    input  logic                  Next_I,
    input  logic                  Rdy_I,
    input  logic                  Found_I,
    output logic                  Update_O,
    output logic                  Clear_O,
    output msg_block_t            Msg_O,
    output logic [BYTE_NUM_W-1:0] ByteNum_O,
    output logic [NONCE_BITS-1:0] Nonce_O,
    output logic                  Busy_O,
    output logic                  Err_O
);

    loader_state_t         state_reg, state_next;
    logic [WCNT_W-1:0]     wcnt_reg, wcnt_next;
    logic [PTR_W-1:0]      ptr_reg, ptr_next;
    logic                  clear_reg, clear_next;
    logic                  err_reg, err_next;
    logic [BYTE_NUM_W-1:0] byte_num_reg, byte_num_next;
    logic [NONCE_BITS-1:0] nonce_reg, nonce_next;

    logic [31:0]           mem_reg [MEM_DEPTH];

    logic                  loading;
    logic                  wr_accept;
    logic                  wr_en;
    logic [WCNT_W-1:0]     wcnt_eff;
    logic [WCNT_W-1:0]     wr_idx;
    logic                  hdr_over;
    logic [BYTE_NUM_W-1:0] hdr_clamped;
    logic [4:0]            n_blocks;
    logic [PTR_W-1:0]      last_ptr;
    msg_block_t            raw_words;

    assign loading   = (state_reg == ST_IDLE) || (state_reg == ST_LOAD);
    assign wr_accept = WrVld_I && loading && !Abort_I;
    // The first word of a job always restarts at header word 0.
    assign wcnt_eff  = (state_reg == ST_IDLE) ? '0 : wcnt_reg;
    assign wr_en     = wr_accept && (wcnt_eff < WCNT_W'(HDR_WORDS));
    assign wr_idx    = WCNT_W'(NONCE_WORDS) + wcnt_eff;

    assign hdr_over    = HdrBytes_I > BYTE_NUM_W'(MAX_HDR_BYTES);
    assign hdr_clamped = hdr_over ? BYTE_NUM_W'(MAX_HDR_BYTES) : HdrBytes_I;

    // last = ceil(ByteNum/64) - 1
    assign n_blocks = byte_num_reg[BYTE_NUM_W-1:6] + {4'd0, |byte_num_reg[5:0]};
    assign last_ptr = PTR_W'(n_blocks - 5'd1);

    assign WrRdy_O   = loading;
    assign Update_O  = (state_reg == ST_ARM);
    assign Busy_O    = (state_reg == ST_ARM) || (state_reg == ST_RUN);
    assign Clear_O   = clear_reg;
    assign Err_O     = err_reg;
    assign ByteNum_O = byte_num_reg;
    assign Nonce_O   = nonce_reg;

    always_comb begin
        state_next    = state_reg;
        wcnt_next     = wcnt_reg;
        ptr_next      = ptr_reg;
        clear_next    = 1'b0;
        err_next      = err_reg;
        byte_num_next = byte_num_reg;
        nonce_next    = nonce_reg;

        if (Abort_I) begin
            state_next = ST_IDLE;
            wcnt_next  = '0;
            ptr_next   = '0;
            // Only a miner that was started needs clearing.
            clear_next = Busy_O;
        end else begin
            case (state_reg)
                ST_IDLE, ST_LOAD: begin
                    if (WrVld_I) begin
                        if (state_reg == ST_IDLE) begin
                            err_next = 1'b0;
                        end
                        if (wcnt_eff == WCNT_W'(HDR_WORDS)) begin
                            err_next = 1'b1;
                        end else begin
                            wcnt_next = wcnt_eff + WCNT_W'(1);
                        end
                        if (WrLast_I) begin
                            byte_num_next = BYTE_NUM_W'(NONCE_BYTE_LEN) + hdr_clamped;
                            nonce_next    = Nonce_I;
                            ptr_next      = '0;
                            state_next    = ST_ARM;
                            if (hdr_over) begin
                                err_next = 1'b1;
                            end
                        end else begin
                            state_next = ST_LOAD;
                        end
                    end
                end
                ST_ARM: begin
                    ptr_next   = '0;
                    state_next = ST_RUN;
                end
                ST_RUN: begin
                    if (Found_I) begin
                        clear_next = 1'b1;
                        wcnt_next  = '0;
                        state_next = ST_IDLE;
                    end else if (Rdy_I) begin
                        ptr_next = '0;
                    end else if (Next_I && (ptr_reg != last_ptr)) begin
                        ptr_next = ptr_reg + PTR_W'(1);
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_reg    <= ST_IDLE;
            wcnt_reg     <= '0;
            ptr_reg      <= '0;
            clear_reg    <= 1'b0;
            err_reg      <= 1'b0;
            byte_num_reg <= '0;
            nonce_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            wcnt_reg     <= wcnt_next;
            ptr_reg      <= ptr_next;
            clear_reg    <= clear_next;
            err_reg      <= err_next;
            byte_num_reg <= byte_num_next;
            nonce_reg    <= nonce_next;
        end
    end

    // Header storage; contents are only meaningful below ByteNum, so no reset.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem_reg[wr_idx] <= WrData_I;
        end
    end

    // The nonce slot is never written and always reads as zero.
    genvar gi;
    generate
        for (gi = 0; gi < MSG_WORDS; gi++) begin : g_read
            logic [WCNT_W-1:0] rd_idx;
            assign rd_idx = {ptr_reg, 4'(gi)};
            assign raw_words[gi] = (rd_idx < WCNT_W'(NONCE_WORDS)) ? 32'h0 : mem_reg[rd_idx];
        end
    endgenerate

    msg_block_mask u_mask (
        .ptr          (ptr_reg),
        .byte_num     (byte_num_reg),
        .raw_words    (raw_words),
        .masked_words (Msg_O)
    );

endmodule

// File: tb/tb_miner_job_loader.sv
module tb_miner_job_loader;
    import miner_pkg::*;

    logic                  Clk = 1'b0;
    logic                  Rst_n;
    logic                  WrVld_I;
    logic [31:0]           WrData_I;
    logic                  WrLast_I;
    logic [BYTE_NUM_W-1:0] HdrBytes_I;
    logic [NONCE_BITS-1:0] Nonce_I;
    logic                  WrRdy_O;
    logic                  Abort_I;
    logic                  Next_I;
    logic                  Rdy_I;
    logic                  Found_I;
    logic                  Update_O;
    logic                  Clear_O;
    msg_block_t            Msg_O;
    logic [BYTE_NUM_W-1:0] ByteNum_O;
    logic [NONCE_BITS-1:0] Nonce_O;
    logic                  Busy_O;
    logic                  Err_O;

    miner_job_loader dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .WrVld_I    (WrVld_I),
        .WrData_I   (WrData_I),
        .WrLast_I   (WrLast_I),
        .HdrBytes_I (HdrBytes_I),
        .Nonce_I    (Nonce_I),
        .WrRdy_O    (WrRdy_O),
        .Abort_I    (Abort_I),
        .Next_I     (Next_I),
        .Rdy_I      (Rdy_I),
        .Found_I    (Found_I),
        .Update_O   (Update_O),
        .Clear_O    (Clear_O),
        .Msg_O      (Msg_O),
        .ByteNum_O  (ByteNum_O),
        .Nonce_O    (Nonce_O),
        .Busy_O     (Busy_O),
        .Err_O      (Err_O)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the message as a byte string (nonce slot, then header
    // words big-endian), truncated at the message length.
    logic [31:0]  mdl_words [250];
    int           mdl_bytenum = 0;
    logic [191:0] mdl_nonce   = '0;
    bit           mdl_err     = 1'b0;
    int           mdl_ptr     = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [7:0] msg_byte(input int b);
        logic [31:0] word;
        int          k;
        if (b < NONCE_BYTE_LEN || b >= mdl_bytenum) return 8'h00;
        k    = b - NONCE_BYTE_LEN;
        word = mdl_words[k / 4];
        return word[31 - 8 * (k % 4) -: 8];
    endfunction

    function automatic logic [511:0] exp_block(input int p);
        logic [511:0] blk;
        blk = '0;
        for (int w = 0; w < 16; w++)
            for (int l = 0; l < 4; l++)
                blk[w * 32 + 31 - 8 * l -: 8] = msg_byte(p * 64 + w * 4 + l);
        return blk;
    endfunction

    function automatic int last_blk();
        return (mdl_bytenum + 63) / 64 - 1;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wrrdy"},  WrRdy_O,   1);
        check({tag, "_update"}, Update_O,  0);
        check({tag, "_clear"},  Clear_O,   0);
        check({tag, "_busy"},   Busy_O,    0);
        check({tag, "_err"},    Err_O,     0);
        check({tag, "_msg"},    Msg_O,     0);
        check({tag, "_bytenum"}, ByteNum_O, 0);
        check({tag, "_nonce"},  Nonce_O,   0);
    endtask

    // Streams a job and returns one cycle after WrLast_I, i.e. in the arm cycle.
    task automatic load_job(input int nwords, input int hdr_bytes, input logic [191:0] nonce);
        logic [31:0] d;
        $display("job: %0d words, HdrBytes=%0d", nwords, hdr_bytes);
        for (int i = 0; i < nwords; i++) begin
            d          = $urandom;
            WrVld_I    = 1'b1;
            WrData_I   = d;
            WrLast_I   = (i == nwords - 1);
            HdrBytes_I = 11'(hdr_bytes);
            Nonce_I    = nonce;
            if (i == 0) mdl_err = 1'b0;
            if (i < 250) mdl_words[i] = d;
            else         mdl_err = 1'b1;
            if (i == nwords - 1) begin
                mdl_bytenum = NONCE_BYTE_LEN + ((hdr_bytes > MAX_HDR_BYTES) ? MAX_HDR_BYTES : hdr_bytes);
                mdl_nonce   = nonce;
                if (hdr_bytes > MAX_HDR_BYTES) mdl_err = 1'b1;
            end
            tick();
            if (i == 0 && nwords > 1) check("err_after_first_word", Err_O, mdl_err);
        end
        WrVld_I  = 1'b0;
        WrLast_I = 1'b0;
        mdl_ptr  = 0;
        check("arm_update",  Update_O,  1);
        check("arm_busy",    Busy_O,    1);
        check("arm_wrrdy",   WrRdy_O,   0);
        check("arm_bytenum", ByteNum_O, mdl_bytenum);
        check("arm_nonce",   Nonce_O,   mdl_nonce);
        check("arm_err",     Err_O,     mdl_err);
        check("arm_msg",     Msg_O,     exp_block(0));
    endtask

    task automatic enter_run();
        tick();
        check("run_update", Update_O, 0);
        check("run_busy",   Busy_O,   1);
        check("run_msg",    Msg_O,    exp_block(mdl_ptr));
    endtask

    task automatic step(input bit nxt, input bit rdy);
        Next_I = nxt;
        Rdy_I  = rdy;
        tick();
        Next_I = 1'b0;
        Rdy_I  = 1'b0;
        if (rdy)      mdl_ptr = 0;
        else if (nxt) mdl_ptr = (mdl_ptr < last_blk()) ? mdl_ptr + 1 : mdl_ptr;
        $display("step: next=%0d rdy=%0d -> block %0d", nxt, rdy, mdl_ptr);
        check("step_msg", Msg_O, exp_block(mdl_ptr));
    endtask

    task automatic finish_job(input bit found, input bit abort);
        Found_I = found;
        Abort_I = abort;
        tick();
        Found_I = 1'b0;
        Abort_I = 1'b0;
        check("end_clear", Clear_O, 1);
        check("end_wrrdy", WrRdy_O, 1);
        check("end_busy",  Busy_O,  0);
        tick();
        check("end_clear_single", Clear_O, 0);
    endtask

    initial begin
        logic [191:0] rnd_nonce;
        int           nw;
        int           sel;

        Rst_n = 1'b0; WrVld_I = 1'b0; WrData_I = '0; WrLast_I = 1'b0;
        HdrBytes_I = '0; Nonce_I = '0; Abort_I = 1'b0; Next_I = 1'b0;
        Rdy_I = 1'b0; Found_I = 1'b0;
        #23;
        check_reset_outputs("reset");
        Rst_n = 1'b1;
        tick();

        // 40-byte header, known nonce
        load_job(10, 40, 192'h0102030405060708090a0b0c0d0e0f101112131415161718);
        enter_run();
        finish_job(1'b1, 1'b0);

        // 100-byte header: block 1 tail masked, pointer saturates at 1
        load_job(25, 100, {6{$urandom}});
        enter_run();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        finish_job(1'b1, 1'b0);

        // Overflow: 260 beats, HdrBytes 1040
        load_job(260, 1040, {6{$urandom}});
        enter_run();
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0);
        finish_job(1'b0, 1'b1);

        // Next job's first word clears Err_O; abort during arm
        load_job(3, 12, {6{$urandom}});
        Abort_I = 1'b1;
        tick();
        Abort_I = 1'b0;
        check("abort_arm_update", Update_O, 0);
        check("abort_arm_clear",  Clear_O,  1);
        check("abort_arm_busy",   Busy_O,   0);
        tick();
        check("abort_arm_clear_single", Clear_O, 0);

        // Asynchronous reset in the middle of a run
        load_job(40, 157, {6{$urandom}});
        enter_run();
        step(1'b1, 1'b0);
        #2;
        Rst_n = 1'b0;
        #1;
        mdl_bytenum = 0; mdl_nonce = '0; mdl_err = 1'b0; mdl_ptr = 0;
        check_reset_outputs("midrun_reset");
        @(negedge Clk);
        Rst_n = 1'b1;
        tick();

        // Randomised jobs
        for (int j = 0; j < 8; j++) begin
            nw        = $urandom_range(1, 250);
            rnd_nonce = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            load_job(nw, nw * 4 - $urandom_range(0, 3), rnd_nonce);
            enter_run();
            for (int s = 0; s < 24; s++)
                step(1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0));
            sel = $urandom_range(0, 2);
            finish_job(sel != 1, sel != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
